// File: rtl/stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// stall_ctrl_if -- hazard-request / stall-bus bundle for stall_ctrl.
//
// Signals
//   stallreq_for_id  load-use hazard from ID, valid in the same cycle
//   stallreq_for_ex  multi-cycle divide resident in EX
//   div_ready        one-cycle "divider result valid" pulse
//   clear_cnt        synchronous clear of the stall performance counter
//   stall            stall bus, bit0=PC .. bit5=WB, 1 = stop
//   div_start        one-cycle start pulse to the shared divider
//   stall_cnt        saturating count of cycles with stall[0]=1
//   div_timeout      sticky divider-watchdog flag
//
// Modports
//   master  pipeline side: raises requests, consumes the stall bus
//   slave   stall_ctrl side
// ---------------------------------------------------------------------------
interface stall_ctrl_if #(
   parameter int STALL_W = 6,
   parameter int CNT_W   = 16
);
   logic               stallreq_for_id;
   logic               stallreq_for_ex;
   logic               div_ready;
   logic               clear_cnt;
   logic [STALL_W-1:0] stall;
   logic               div_start;
   logic [CNT_W-1:0]   stall_cnt;
   logic               div_timeout;

   modport master (
      output stallreq_for_id, stallreq_for_ex, div_ready, clear_cnt,
      input  stall, div_start, stall_cnt, div_timeout
   );

   modport slave (
      input  stallreq_for_id, stallreq_for_ex, div_ready, clear_cnt,
      output stall, div_start, stall_cnt, div_timeout
   );
endinterface

// File: rtl/stall_ctrl.sv
// ---------------------------------------------------------------------------
// stall_ctrl -- pipeline stall controller.
//
// Resolves load-use hazards (bubble into EX) and multi-cycle divides
// (hold through EX while the shared divider is busy, bubble into MEM).
// A watchdog forces the divider hold to release after DIV_TIMEOUT BUSY
// cycles and latches a sticky div_timeout flag.  A saturating counter
// tracks how many cycles the PC was stalled.
//
// Ports
//   clk   single clock, all state updates on its rising edge
//   rst   asynchronous, active-high reset
//   bus   stall_ctrl_if.slave (requests in, stall bus / status out)
//
// Parameters
//   STALL_W      stall bus width
//   DIV_TIMEOUT  max BUSY cycles before a forced divider release
//   CNT_W        stall performance counter width
// ---------------------------------------------------------------------------
module stall_ctrl #(
   parameter int STALL_W     = 6,
   parameter int DIV_TIMEOUT = 40,
   parameter int CNT_W       = 16
) (
   input logic         clk,
   input logic         rst,
   stall_ctrl_if.slave bus
);

   // Wait counter only needs to reach DIV_TIMEOUT-1.
   localparam int WAIT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIV_TIMEOUT - 1);

   // Stall encodings: ID_BUBBLE holds PC/IF/ID, EX_HOLD additionally holds EX.
   localparam logic [STALL_W-1:0] STALL_NONE = '0;
   localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
   localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]         state_q;
   logic [0:0]         state_d;
   logic [WAIT_W-1:0]  wait_q;
   logic [WAIT_W-1:0]  wait_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               timeout_q;
   logic               timeout_set;
   logic [STALL_W-1:0] stall_c;
   logic               start_c;

   // Release-cycle stall: a pending load-use hazard still needs its bubble.
   logic [STALL_W-1:0] release_stall;
   assign release_stall = bus.stallreq_for_id ? STALL_ID : STALL_NONE;

   // -----------------------------------------------------------------------
   // Next-state and stall decode
   // -----------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned -- otherwise synthesis infers a latch.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      stall_c     = STALL_NONE;
      start_c     = 1'b0;
      timeout_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // EX request wins over ID; the ID hazard is seen again after release.
            if (bus.stallreq_for_ex) begin
               stall_c = STALL_EX;
               start_c = 1'b1;
               state_d = ST_BUSY;
               wait_d  = '0;
            end else if (bus.stallreq_for_id) begin
               stall_c = STALL_ID;
            end
         end

         ST_BUSY: begin
            // Only div_ready or the watchdog ends the hold; requests are ignored.
            if (bus.div_ready || (wait_q == WAIT_LAST)) begin
               stall_c     = release_stall;
               state_d     = ST_IDLE;
               timeout_set = ~bus.div_ready;
            end else begin
               stall_c = STALL_EX;
               wait_d  = wait_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs must read as quiet for the whole time reset is held, not
      // just after the registers have cleared.
      if (rst) begin
         stall_c = STALL_NONE;
         start_c = 1'b0;
      end
   end

   // -----------------------------------------------------------------------
   // FSM, wait counter and watchdog flag
   // -----------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (timeout_set) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Saturating stall counter; clear beats increment
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (bus.clear_cnt) begin
         cnt_q <= '0;
      end else if (stall_c[0] && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.stall       = stall_c;
   assign bus.div_start   = start_c;
   assign bus.stall_cnt   = cnt_q;
   assign bus.div_timeout = timeout_q;

   // -----------------------------------------------------------------------
   // Protocol properties
   // -----------------------------------------------------------------------
   // A start pulse is only ever issued from IDLE and never on two cycles in a row.
   a_start_idle : assert property (@(posedge clk) disable iff (rst)
      bus.div_start |-> (state_q == ST_IDLE));

   a_start_single : assert property (@(posedge clk) disable iff (rst)
      bus.div_start |=> !bus.div_start);

endmodule

// File: tb/tb_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stall_ctrl -- scoreboard bench for stall_ctrl.
// The driver applies one cycle of inputs, asks the reference model what the
// controller should show in that cycle and queues it; the monitor pops one
// entry at every falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_stall_ctrl;

   localparam int STALL_W     = 6;
   localparam int DIV_TIMEOUT = 40;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   localparam int S_NONE = 6'b000000;
   localparam int S_ID   = 6'b000111;
   localparam int S_EX   = 6'b001111;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stall_ctrl_if #(.STALL_W(STALL_W), .CNT_W(CNT_W)) bus ();

   stall_ctrl #(
      .STALL_W    (STALL_W),
      .DIV_TIMEOUT(DIV_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int stall;
      int start;
      int cnt;
      int to;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;

   // Reference model: "busy" means a divide is outstanding; busy_age counts
   // how many BUSY cycles that divide has spent, including the current one.
   bit m_busy   = 1'b0;
   int busy_age = 0;
   int m_cnt    = 0;
   bit m_to     = 1'b0;

   task automatic check(input string name, input int act, input int exp, input int at);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, at, act, exp);
      end
   endtask

   // Drive one cycle and queue the behaviour the controller must show.
   task automatic drive(input bit id, input bit ex, input bit rdy, input bit clr, input bit r);
      exp_t e;
      int   s;
      bit   st;
      @(posedge clk);
      #1;
      bus.stallreq_for_id = id;
      bus.stallreq_for_ex = ex;
      bus.div_ready       = rdy;
      bus.clear_cnt       = clr;
      rst                 = r;
      cyc++;
      s  = S_NONE;
      st = 1'b0;
      if (r) begin
         m_busy   = 1'b0;
         busy_age = 0;
         m_cnt    = 0;
         m_to     = 1'b0;
      end
      e.cnt = m_cnt;
      e.to  = int'(m_to);
      e.cyc = cyc;
      if (!r) begin
         if (!m_busy) begin
            if (ex) begin
               s        = S_EX;
               st       = 1'b1;
               m_busy   = 1'b1;
               busy_age = 0;
            end else if (id) begin
               s = S_ID;
            end
         end else begin
            busy_age++;
            if (rdy || busy_age == DIV_TIMEOUT) begin
               s      = id ? S_ID : S_NONE;
               m_busy = 1'b0;
               if (!rdy) m_to = 1'b1;
            end else begin
               s = S_EX;
            end
         end
         if (clr) m_cnt = 0;
         else if ((s & 1) != 0 && m_cnt < CNT_MAX) m_cnt++;
      end
      e.stall = s;
      e.start = int'(st);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",       int'(bus.stall),       e.stall, e.cyc);
            check("div_start",   int'(bus.div_start),   e.start, e.cyc);
            check("stall_cnt",   int'(bus.stall_cnt),   e.cnt,   e.cyc);
            check("div_timeout", int'(bus.div_timeout), e.to,    e.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.stallreq_for_id = 1'b0;
      bus.stallreq_for_ex = 1'b0;
      bus.div_ready       = 1'b0;
      bus.clear_cnt       = 1'b0;

      // Reset state, with requests active to prove they are masked.
      drive(1, 1, 1, 0, 1);
      drive(0, 0, 0, 0, 1);
      idle(2);

      // Load-use bubble for one cycle.
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      check("loaduse_cnt", int'(bus.stall_cnt), 1, cyc);
      idle(1);

      // Divide released by div_ready at cycle 10.
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);
      drive(0, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      check("divide_cnt", int'(bus.stall_cnt), 10, cyc);
      idle(2);

      // Both requests together; release with the ID hazard still pending.
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      idle(2);

      // div_ready while idle is ignored.
      drive(0, 0, 1, 0, 0);
      idle(1);

      // Back-to-back divides with the EX request held continuously.
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0);
         drive(0, 1, 0, 0, 0);
         drive(0, 1, 1, 0, 0);
      end
      idle(2);

      // Watchdog: div_ready never arrives.
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < DIV_TIMEOUT; i++) drive(0, 1, 0, 0, 0);
      idle(1);
      check("timeout_set", int'(bus.div_timeout), 1, cyc);
      idle(5);
      check("timeout_sticky", int'(bus.div_timeout), 1, cyc);

      // Counter saturation, then clear while stall is active.
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0);
      check("sat_cnt", int'(bus.stall_cnt), CNT_MAX, cyc);
      drive(0, 0, 0, 0, 0);
      check("clear_cnt", int'(bus.stall_cnt), 0, cyc);

      // Reset in the middle of a divide, then a stray div_ready.
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 1);
      drive(0, 0, 1, 0, 0);
      check("reset_cnt", int'(bus.stall_cnt), 0, cyc);
      idle(2);

      // Random traffic: frequent div_ready, then rare div_ready for timeouts.
      for (int i = 0; i < 2000; i++)
         drive($urandom_range(2) == 0, $urandom_range(4) == 0, $urandom_range(5) == 0,
               $urandom_range(15) == 0, $urandom_range(249) == 0);
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(59) == 0,
               $urandom_range(30) == 0, $urandom_range(499) == 0);

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0, cyc);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
